// File: rtl/bsg_gateway_iodelay_pkg.sv
// rtl/bsg_gateway_iodelay_pkg.sv - shared types and limits for the gateway output delay tuner
package bsg_gateway_iodelay_pkg;

    typedef enum logic [2:0] {
        RST_DLY,
        INIT,
        IDLE,
        STEP,
        SETTLE,
        ERR
    } tuner_state_e;

    localparam int tap_width_gp = 8;
    localparam int max_tap_gp   = 255;

endpackage

// File: rtl/bsg_gateway_iodelay_var_output.sv
// rtl/bsg_gateway_iodelay_var_output.sv - one variable ODATAIN delay element (IODELAY2 stand-in)
module bsg_gateway_iodelay_var_output #(
    parameter int tap_width_p = 8,
    parameter int max_tap_p   = 255
) (
    input  logic                   clk_i,
    input  logic                   ce_i,
    input  logic                   inc_i,
    input  logic                   rst_i,
    input  logic                   bit_i,
    output logic                   bit_o,
    output logic [tap_width_p-1:0] tap_o
);

    localparam logic [tap_width_p-1:0] max_l = tap_width_p'(max_tap_p);

    // Models IODELAY2 (DELAY_SRC "ODATAIN", IDELAY_TYPE "VARIABLE_FROM_ZERO",
    // DATA_RATE "DDR", COUNTER_WRAPAROUND "STAY_AT_LIMIT"); the pad delay itself is not modelled.
    logic [tap_width_p-1:0] tap_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_q <= '0;
        end else if (ce_i) begin
            if (inc_i && tap_q != max_l) begin
                tap_q <= tap_q + 1'b1;
            end else if (!inc_i && tap_q != '0) begin
                tap_q <= tap_q - 1'b1;
            end
        end
    end

    assign bit_o = bit_i;
    assign tap_o = tap_q;

endmodule

// File: rtl/bsg_gateway_iodelay_output_tuner.sv
// rtl/bsg_gateway_iodelay_output_tuner.sv - per-channel output tap controller with init ramp
module bsg_gateway_iodelay_output_tuner
    import bsg_gateway_iodelay_pkg::*;
#(
    parameter int channels_p  = 8,
    parameter int tap_width_p = tap_width_gp,
    parameter int max_tap_p   = max_tap_gp,
    parameter int init_tap_p  = 0,
    parameter int settle_p    = 2,
    localparam int chan_w     = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [channels_p-1:0]             data_i,
    output logic [channels_p-1:0]             data_o,
    input  logic                              cfg_v_i,
    input  logic [chan_w-1:0]                 cfg_chan_i,
    input  logic [tap_width_p-1:0]            cfg_tap_i,
    output logic                              cfg_ready_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic [channels_p*tap_width_p-1:0] tap_o
);

    localparam int cnt_w = (settle_p > 1) ? $clog2(settle_p) : 1;
    localparam logic [cnt_w-1:0]       settle_last = cnt_w'(settle_p - 1);
    localparam logic [tap_width_p-1:0] max_l  = tap_width_p'(max_tap_p);
    localparam logic [tap_width_p-1:0] init_l = tap_width_p'((init_tap_p < max_tap_p) ? init_tap_p : max_tap_p);

    tuner_state_e            state_q, state_n, ret_q, ret_n;
    logic [cnt_w-1:0]        cnt_q, cnt_n;
    logic [chan_w-1:0]       chan_q, chan_n;
    logic [tap_width_p-1:0]  target_q, target_n, cur;
    logic [tap_width_p-1:0]  shadow_q [channels_p];
    logic [tap_width_p-1:0]  shadow_n [channels_p];
    logic [channels_p-1:0]   ce_q, ce_n;
    logic                    inc_q, inc_n, at_init, step_up;
    logic [tap_width_p-1:0]  hw_tap_unused [channels_p];

    always_comb begin
        at_init = 1'b1;
        for (int c = 0; c < channels_p; c++) begin
            if (shadow_q[c] != init_l) at_init = 1'b0;
        end
    end

    assign cur     = shadow_q[chan_q];
    assign step_up = target_q > cur;

    always_comb begin
        state_n     = state_q;
        ret_n       = ret_q;
        cnt_n       = cnt_q;
        chan_n      = chan_q;
        target_n    = target_q;
        shadow_n    = shadow_q;
        ce_n        = '0;
        inc_n       = 1'b0;
        cfg_ready_o = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            RST_DLY: state_n = INIT;
            INIT: begin
                if (at_init) begin
                    state_n = IDLE;
                end else begin
                    ce_n  = '1;
                    inc_n = 1'b1;
                    for (int c = 0; c < channels_p; c++) begin
                        if (shadow_q[c] != max_l) shadow_n[c] = shadow_q[c] + 1'b1;
                    end
                    ret_n   = INIT;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_v_i) begin
                    chan_n   = cfg_chan_i;
                    target_n = (cfg_tap_i > max_l) ? max_l : cfg_tap_i;
                    state_n  = ({1'b0, cfg_chan_i} >= (chan_w + 1)'(channels_p)) ? ERR : STEP;
                end
            end
            STEP: begin
                if (cur == target_q) begin
                    done_o  = 1'b1;
                    state_n = IDLE;
                end else begin
                    ce_n[chan_q]     = 1'b1;
                    inc_n            = step_up;
                    shadow_n[chan_q] = step_up ? cur + 1'b1 : cur - 1'b1;
                    ret_n            = STEP;
                    cnt_n            = '0;
                    state_n          = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == settle_last) state_n = ret_q;
                else cnt_n = cnt_q + 1'b1;
            end
            ERR: begin
                err_o   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = RST_DLY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RST_DLY;
            ret_q    <= INIT;
            cnt_q    <= '0;
            chan_q   <= '0;
            target_q <= '0;
            ce_q     <= '0;
            inc_q    <= 1'b0;
            for (int c = 0; c < channels_p; c++) shadow_q[c] <= '0;
        end else begin
            state_q  <= state_n;
            ret_q    <= ret_n;
            cnt_q    <= cnt_n;
            chan_q   <= chan_n;
            target_q <= target_n;
            ce_q     <= ce_n;
            inc_q    <= inc_n;
            shadow_q <= shadow_n;
        end
    end

    // Shadows lead the element count by one cycle because CE/INC are registered.
    for (genvar c = 0; c < channels_p; c++) begin : g_chan
        bsg_gateway_iodelay_var_output #(
            .tap_width_p(tap_width_p),
            .max_tap_p  (max_tap_p)
        ) u_dly (
            .clk_i(clk_i),
            .ce_i (ce_q[c]),
            .inc_i(inc_q),
            .rst_i(state_q == RST_DLY),
            .bit_i(data_i[c]),
            .bit_o(data_o[c]),
            .tap_o(hw_tap_unused[c])
        );
        assign tap_o[c*tap_width_p +: tap_width_p] = shadow_q[c];
    end

endmodule

// File: tb/tb_bsg_gateway_iodelay_output_tuner.sv
// tb/tb_bsg_gateway_iodelay_output_tuner.sv - directed self-checking bench for the output tuner
module tb_bsg_gateway_iodelay_output_tuner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_a, dout_a;
    logic        v_a = 1'b0, rdy_a, done_a, err_a;
    logic [2:0]  chan_a = '0;
    logic [7:0]  tap_in_a = '0;
    logic [63:0] tap_a;
    logic [4:0]  data_b, dout_b;
    logic        v_b = 1'b0, rdy_b, done_b, err_b;
    logic [2:0]  chan_b = '0;
    logic [7:0]  tap_in_b = '0;
    logic [39:0] tap_b;

    int compared = 0, mismatched = 0;
    int chg_a [8];
    int done_cnt_a = 0, done_cnt_b = 0;
    logic [7:0] prev_a [8];

    always #5 clk = ~clk;

    bsg_gateway_iodelay_output_tuner #(
        .channels_p(8), .tap_width_p(8), .max_tap_p(63), .init_tap_p(10), .settle_p(2)
    ) dut_a (
        .clk_i(clk), .reset_i(reset), .data_i(data_a), .data_o(dout_a),
        .cfg_v_i(v_a), .cfg_chan_i(chan_a), .cfg_tap_i(tap_in_a),
        .cfg_ready_o(rdy_a), .done_o(done_a), .err_o(err_a), .tap_o(tap_a)
    );

    bsg_gateway_iodelay_output_tuner #(
        .channels_p(5), .tap_width_p(8), .max_tap_p(255), .init_tap_p(3), .settle_p(1)
    ) dut_b (
        .clk_i(clk), .reset_i(reset), .data_i(data_b), .data_o(dout_b),
        .cfg_v_i(v_b), .cfg_chan_i(chan_b), .cfg_tap_i(tap_in_b),
        .cfg_ready_o(rdy_b), .done_o(done_b), .err_o(err_b), .tap_o(tap_b)
    );

    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) begin
            if (tap_a[c*8 +: 8] !== prev_a[c]) chg_a[c]++;
            prev_a[c] = tap_a[c*8 +: 8];
        end
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input bit b, input int chan, input int tap,
                           output int done_cyc, output int err_cyc, output int rdy_next);
        int k = 0;
        while (!(b ? rdy_b : rdy_a) && k < 2000) begin
            cycle();
            k++;
        end
        if (k >= 2000) check("ready_timeout", k, 0);
        if (b) begin v_b = 1'b1; chan_b = 3'(chan); tap_in_b = 8'(tap); end
        else   begin v_a = 1'b1; chan_a = 3'(chan); tap_in_a = 8'(tap); end
        cycle();
        v_a = 1'b0;
        v_b = 1'b0;
        done_cyc = -1;
        err_cyc  = -1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (b ? done_b : done_a) begin done_cyc = cyc; break; end
            if (b ? err_b : err_a)   begin err_cyc  = cyc; break; end
            cycle();
        end
        cycle();
        rdy_next = int'(b ? rdy_b : rdy_a);
    endtask

    task automatic wait_init(output int cyc_a, output int cyc_b);
        cyc_a = -1;
        cyc_b = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (rdy_a && cyc_a < 0) cyc_a = cyc;
            if (rdy_b && cyc_b < 0) cyc_b = cyc;
            if (cyc_a >= 0 && cyc_b >= 0) break;
            cycle();
        end
    endtask

    int dc, ec, rn, ca, cb, base [8], dbase;

    initial begin
        data_a = 8'hA5;
        data_b = 5'h0B;
        for (int c = 0; c < 8; c++) begin chg_a[c] = 0; prev_a[c] = '0; end
        repeat (3) cycle();

        check("rst_ready", rdy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_tap", tap_a, 0);
        check("data_path", dout_a, 8'hA5);

        reset = 1'b0;
        for (int c = 0; c < 8; c++) base[c] = chg_a[c];
        wait_init(ca, cb);
        check("init_ready_cyc_a", ca, 32);
        check("init_ready_cyc_b", cb, 8);
        check("init_tap_a", tap_a, {8{8'd10}});
        check("init_tap_b", tap_b, {5{8'd3}});
        check("init_steps_a3", chg_a[3] - base[3], 10);

        for (int c = 0; c < 8; c++) base[c] = chg_a[c];
        run_req(1'b0, 2, 13, dc, ec, rn);
        check("inc_done_cyc", dc, 10);
        check("inc_ready_next", rn, 1);
        check("inc_tap2", tap_a[16 +: 8], 13);
        check("inc_steps2", chg_a[2] - base[2], 3);
        check("inc_other_tap", {tap_a[63:24], tap_a[15:0]}, {7{8'd10}});

        for (int c = 0; c < 8; c++) base[c] = chg_a[c];
        run_req(1'b0, 2, 5, dc, ec, rn);
        check("dec_done_cyc", dc, 25);
        check("dec_tap2", tap_a[16 +: 8], 5);
        check("dec_steps2", chg_a[2] - base[2], 8);

        for (int c = 0; c < 8; c++) base[c] = chg_a[c];
        run_req(1'b0, 2, 5, dc, ec, rn);
        check("noop_done_cyc", dc, 1);
        check("noop_steps2", chg_a[2] - base[2], 0);

        for (int c = 0; c < 8; c++) base[c] = chg_a[c];
        run_req(1'b0, 0, 100, dc, ec, rn);
        check("clamp_done_cyc", dc, 160);
        check("clamp_tap0", tap_a[0 +: 8], 63);
        check("clamp_steps0", chg_a[0] - base[0], 53);

        dbase = done_cnt_b;
        run_req(1'b1, 5, 9, dc, ec, rn);
        check("bad5_err_cyc", ec, 1);
        check("bad5_ready_next", rn, 1);
        check("bad5_taps", tap_b, {5{8'd3}});
        run_req(1'b1, 7, 0, dc, ec, rn);
        check("bad7_err_cyc", ec, 1);
        check("bad_no_done", done_cnt_b - dbase, 0);
        run_req(1'b1, 4, 0, dc, ec, rn);
        check("b_dec_done_cyc", dc, 7);
        check("b_dec_tap4", tap_b[32 +: 8], 0);

        dbase = done_cnt_a;
        while (!rdy_a) cycle();
        v_a = 1'b1; chan_a = 3'd1; tap_in_a = 8'd40;
        cycle();
        v_a = 1'b0;
        repeat (20) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        check("midrst_taps_zero", tap_a, 0);
        check("midrst_ready", rdy_a, 0);
        reset = 1'b0;
        wait_init(ca, cb);
        check("midrst_ready_cyc", ca, 32);
        check("midrst_tap", tap_a, {8{8'd10}});
        check("midrst_no_done", done_cnt_a - dbase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
